// File: rtl/ps2_controller_if.sv
// PS/2 receiver signal bundle: the two board lines coming in and the
// decoded scan-code strobe/byte going out to keyboard logic.
interface ps2_controller_if;
    logic       ps2_clock;
    logic       ps2_data;
    logic       scan_ready;
    logic [7:0] scan_code;

    // Board/stimulus side: drives the PS/2 lines, observes decoded bytes.
    modport master (
        output ps2_clock,
        output ps2_data,
        input  scan_ready,
        input  scan_code
    );

    // Receiver side: samples the PS/2 lines, produces decoded bytes.
    modport slave (
        input  ps2_clock,
        input  ps2_data,
        output scan_ready,
        output scan_code
    );
endinterface

// File: rtl/ps2_controller.sv
// PS/2 keyboard receiver. Synchronises the asynchronous PS/2 lines into
// clk, detects falling edges of the PS/2 clock and assembles 11-bit
// device-to-host frames (start, 8 data LSB first, odd parity, stop).
// Each valid byte is presented on scan_code with a one-cycle scan_ready.
module ps2_controller #(
    parameter int TIMEOUT_CYCLES = 6000
) (
    input  logic            clk,
    input  logic            reset,
    ps2_controller_if.slave ps2
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          state_reg;
    logic            ck_s1, ck_s2, ck_s3;
    logic            dt_s1, dt_s2;
    logic            fall;
    logic [2:0]      bit_cnt_reg;
    logic [7:0]      shift_reg;
    logic            parity_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic [7:0]      scan_code_reg;
    logic            scan_ready_reg;

    // Synchronisers and edge register; reset to 1 (line idle level) so
    // the first cycle after reset can never look like a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ck_s1 <= 1'b1;
            ck_s2 <= 1'b1;
            ck_s3 <= 1'b1;
            dt_s1 <= 1'b1;
            dt_s2 <= 1'b1;
        end else begin
            ck_s1 <= ps2.ps2_clock;
            ck_s2 <= ck_s1;
            ck_s3 <= ck_s2;
            dt_s1 <= ps2.ps2_data;
            dt_s2 <= dt_s1;
        end
    end

    assign fall = ck_s3 & ~ck_s2;

    // Frame FSM with timeout; all bit handling happens only on a PS/2
    // clock fall, and a fall takes priority over an expiring timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            parity_reg     <= 1'b0;
            to_cnt_reg     <= '0;
            scan_code_reg  <= 8'h00;
            scan_ready_reg <= 1'b0;
        end else begin
            scan_ready_reg <= 1'b0;
            if (fall) begin
                to_cnt_reg <= '0;
                case (state_reg)
                    S_IDLE: begin
                        // A high sample here is a spurious edge, not a start bit.
                        if (!dt_s2) begin
                            state_reg   <= S_DATA;
                            bit_cnt_reg <= '0;
                        end
                    end
                    S_DATA: begin
                        shift_reg   <= {dt_s2, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        parity_reg <= dt_s2;
                        state_reg  <= S_STOP;
                    end
                    S_STOP: begin
                        // Accept only with a high stop bit and odd overall parity.
                        if (dt_s2 && ((^shift_reg) ^ parity_reg)) begin
                            scan_code_reg  <= shift_reg;
                            scan_ready_reg <= 1'b1;
                        end
                        state_reg <= S_IDLE;
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end else if (state_reg != S_IDLE) begin
                // Abandon a partial frame once the PS/2 clock has stalled.
                if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_reg  <= S_IDLE;
                    to_cnt_reg <= '0;
                end else begin
                    to_cnt_reg <= to_cnt_reg + 1'b1;
                end
            end else begin
                to_cnt_reg <= '0;
            end
        end
    end

    assign ps2.scan_code  = scan_code_reg;
    assign ps2.scan_ready = scan_ready_reg;

endmodule

// File: tb/tb_ps2_controller.sv
// Self-checking bench for ps2_controller: directed scenarios followed by
// random frames with injected parity/stop errors, checked against a
// frame-level model of what bytes should be reported and when.
module tb_ps2_controller;

    localparam int TO = 200;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   cyc;

    ps2_controller_if ifc ();

    ps2_controller #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ps2  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed pulses: byte and cycle of each scan_ready sample.
    logic [7:0] pulse_code[$];
    int         pulse_cyc[$];
    logic       prev_ready;
    int         fall_cyc;
    logic [7:0] exp_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record every strobe; a strobe must never last two cycles.
    always @(negedge clk) begin
        if (ifc.scan_ready === 1'b1) begin
            pulse_code.push_back(ifc.scan_code);
            pulse_cyc.push_back(cyc);
            chk("ready_single_cycle", {31'd0, prev_ready}, 32'd0);
        end
        prev_ready <= ifc.scan_ready;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        int h;
        h = $urandom_range(2, 10);
        ifc.ps2_data = b;
        wait_clks(h);
        ifc.ps2_clock = 1'b0;
        fall_cyc = cyc;
        wait_clks(h);
        ifc.ps2_clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        logic [10:0] bits;
        bits = {stp, par, d, 1'b0};
        for (int i = 0; i < 11; i++) drive_bit(bits[i]);
        ifc.ps2_data = 1'b1;
    endtask

    // Send one frame and compare against the frame rules: valid iff the
    // stop bit is 1 and data+parity hold an odd number of ones.
    task automatic frame_check(input string tag, input logic [7:0] d, input logic par,
                               input logic stp);
        int  n0;
        bit  valid;
        n0    = pulse_code.size();
        valid = stp && ((($countones(d) + int'(par)) % 2) == 1);
        send_frame(d, par, stp);
        wait_clks(8);
        chk({tag, "_pulses"}, pulse_code.size(), n0 + (valid ? 1 : 0));
        if (valid) begin
            exp_code = d;
            if (pulse_code.size() > n0) begin
                chk({tag, "_byte"}, {24'd0, pulse_code[n0]}, {24'd0, d});
                chk({tag, "_latency"}, pulse_cyc[n0], fall_cyc + 3);
            end
        end
        chk({tag, "_scan_code"}, {24'd0, ifc.scan_code}, {24'd0, exp_code});
        $display("frame %s data=%02h par=%0d stop=%0d valid=%0d scan_code=%02h", tag, d, par,
                 stp, valid, ifc.scan_code);
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~(^d);
    endfunction

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;
        errors = 0;
        checks = 0;
        cyc = 0;
        prev_ready = 1'b0;
        fall_cyc = 0;
        exp_code = 8'h00;
        ifc.ps2_clock = 1'b1;
        ifc.ps2_data = 1'b1;
        reset = 1'b1;
        wait_clks(2);
        chk("reset_ready", {31'd0, ifc.scan_ready}, 32'd0);
        chk("reset_code", {24'd0, ifc.scan_code}, 32'd0);
        reset = 1'b0;
        wait_clks(3);

        // Valid frame
        frame_check("valid_1E", 8'h1E, 1'b1, 1'b1);
        // Parity error then valid 1C
        frame_check("parerr_1E", 8'h1E, 1'b0, 1'b1);
        frame_check("valid_1C", 8'h1C, 1'b0, 1'b1);
        // Framing error then valid F0
        frame_check("stoperr_F0", 8'hF0, 1'b1, 1'b0);
        frame_check("valid_F0", 8'hF0, 1'b1, 1'b1);

        // Timeout: start + 4 data bits, then idle
        begin
            int n0;
            n0 = pulse_code.size();
            drive_bit(1'b0);
            for (int i = 0; i < 4; i++) drive_bit(1'b1);
            ifc.ps2_data = 1'b1;
            wait_clks(TO + 10);
            chk("timeout_no_pulse", pulse_code.size(), n0);
            $display("timeout partial frame abandoned pulses=%0d", pulse_code.size() - n0);
        end
        frame_check("after_timeout_1E", 8'h1E, 1'b1, 1'b1);

        // Reset after 6 bits of a frame
        begin
            int n0;
            n0 = pulse_code.size();
            drive_bit(1'b0);
            for (int i = 0; i < 5; i++) drive_bit(i[0]);
            ifc.ps2_data = 1'b1;
            reset = 1'b1;
            wait_clks(2);
            reset = 1'b0;
            wait_clks(2);
            exp_code = 8'h00;
            chk("midreset_ready", {31'd0, ifc.scan_ready}, 32'd0);
            chk("midreset_code", {24'd0, ifc.scan_code}, 32'd0);
            chk("midreset_no_pulse", pulse_code.size(), n0);
            $display("mid-frame reset scan_code=%02h", ifc.scan_code);
        end
        frame_check("after_reset_1E", 8'h1E, 1'b1, 1'b1);

        // Spurious falling edge with data high while idle
        drive_bit(1'b1);
        wait_clks(4);
        frame_check("after_spurious_1C", 8'h1C, 1'b0, 1'b1);

        // Back-to-back prefix/release sequence
        frame_check("b2b_E0", 8'hE0, odd_par(8'hE0), 1'b1);
        frame_check("b2b_F0", 8'hF0, odd_par(8'hF0), 1'b1);
        frame_check("b2b_75", 8'h75, odd_par(8'h75), 1'b1);

        // Random frames with occasional parity or stop errors
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom_range(0, 255));
            p = odd_par(d);
            s = 1'b1;
            if ($urandom_range(0, 3) == 0) p = ~p;
            if ($urandom_range(0, 7) == 0) s = 1'b0;
            frame_check("random", d, p, s);
        end

        wait_clks(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
